// File: rtl/boot_rom_copier.sv
// boot_rom_copier: power-up sequencer that copies the boot image from the
// video-cache DPRAM into SDRAM through the sram_wb copy port. The system is
// held off (sys_ready low) until every word has been written or skipped.
//
// Each word goes through a read / latency / write / wait-for-ack / advance
// sequence. Strobes and status outputs are decoded from the registered state,
// so they change only on clock edges and return to their idle values on the
// edge that samples reset.

module boot_rom_copier #(
    parameter int unsigned INIT_WAIT    = 500000,        // settle cycles after reset
    parameter logic [24:0] BASE_ADDR    = 25'h0080000,   // SDRAM byte address of cache word 0
    parameter int unsigned CACHE_RD_LAT = 2,             // cache read latency, 1..7
    parameter int unsigned ACK_TIMEOUT  = 255,           // WRWAIT cycles before a word is skipped
    parameter int unsigned IMAGE_WORDS  = 32768          // words copied, 1..32768
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic [15:0] cache_addr,
    output logic        cache_rd,
    input  logic [15:0] cache_q,
    output logic        mem_copy,
    output logic [24:0] mem_copy_addr,
    output logic [15:0] mem_copy_data,
    output logic        mem_copy_we,
    input  logic        mem_ack,
    output logic        sys_ready,
    output logic        copy_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_RD,
        S_RDLAT,
        S_WR,
        S_WRWAIT,
        S_NEXT,
        S_DONE
    } state_e;

    localparam int unsigned WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
    localparam int unsigned TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);
    localparam logic [2:0]        LAT_LAST  = 3'(CACHE_RD_LAT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    // Byte address of the final word. For a full 32768-word image this is
    // 16'hFFFE, so finishing it is the same as the address wrapping to 0.
    localparam logic [15:0]       LAST_ADDR = 16'(2 * (IMAGE_WORDS - 1));

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       cache_addr_q, cache_addr_d;
    logic [24:0]       mem_copy_addr_q, mem_copy_addr_d;
    logic [15:0]       mem_copy_data_q, mem_copy_data_d;
    logic              copy_err_q, copy_err_d;

    // Next-state and datapath updates for the per-word copy sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        lat_cnt_d       = lat_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        cache_addr_d    = cache_addr_q;
        mem_copy_addr_d = mem_copy_addr_q;
        mem_copy_data_d = mem_copy_data_q;
        copy_err_d      = copy_err_q;

        case (state_q)
            S_WAIT: begin
                if (INIT_WAIT == 0 || wait_cnt_q == WAIT_LAST) begin
                    state_d = S_RD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_RD: begin
                lat_cnt_d = '0;
                state_d   = S_RDLAT;
            end

            S_RDLAT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    // Data and address are captured together so both are
                    // already valid in the first cycle mem_copy_we is high.
                    mem_copy_data_d = cache_q;
                    mem_copy_addr_d = BASE_ADDR + {9'd0, cache_addr_q};
                    state_d         = S_WR;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            S_WR: begin
                tmo_cnt_d = '0;
                state_d   = S_WRWAIT;
            end

            S_WRWAIT: begin
                if (mem_ack) begin
                    state_d = S_NEXT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Give up on this word: flag it and move on without retry.
                    copy_err_d = 1'b1;
                    state_d    = S_NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            S_NEXT: begin
                cache_addr_d = cache_addr_q + 16'd2;
                state_d      = (cache_addr_q == LAST_ADDR) ? S_DONE : S_RD;
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state_q         <= S_WAIT;
            wait_cnt_q      <= '0;
            lat_cnt_q       <= '0;
            tmo_cnt_q       <= '0;
            cache_addr_q    <= '0;
            mem_copy_addr_q <= BASE_ADDR;
            mem_copy_data_q <= '0;
            copy_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            lat_cnt_q       <= lat_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            cache_addr_q    <= cache_addr_d;
            mem_copy_addr_q <= mem_copy_addr_d;
            mem_copy_data_q <= mem_copy_data_d;
            copy_err_q      <= copy_err_d;
        end
    end

    // Strobes and status decoded from the registered state.
    assign cache_rd      = (state_q == S_RD);
    assign mem_copy_we   = (state_q == S_WR) || (state_q == S_WRWAIT);
    assign sys_ready     = (state_q == S_DONE);
    assign mem_copy      = (state_q != S_DONE);
    assign busy          = (state_q != S_WAIT) && (state_q != S_DONE);

    assign cache_addr    = cache_addr_q;
    assign mem_copy_addr = mem_copy_addr_q;
    assign mem_copy_data = mem_copy_data_q;
    assign copy_err      = copy_err_q;

endmodule

// File: tb/tb_boot_rom_copier.sv
// Testbench for boot_rom_copier: cache and SDRAM behavioural models, a
// start-up vector table, and a scoreboard of every word written to SDRAM.
// The cache returns addr ^ 16'hA5A5 exactly CACHE_RD_LAT cycles after a read
// strobe and random junk otherwise. The SDRAM model acks after a random
// delay, never acks word 0x0010, and throws stray acks while no write is up.

module tb_boot_rom_copier;

    localparam int          INIT_WAIT = 4;
    localparam int          LAT       = 3;
    localparam int          TMO       = 8;
    localparam int          WORDS     = 2400;
    localparam int          BUDGET    = 30000;
    localparam logic [24:0] BASE      = 25'h0080000;
    localparam logic [15:0] SKIP_ADDR = 16'h0010;
    localparam logic [15:0] RST_ADDR  = 16'h1234;
    localparam logic [15:0] PATTERN   = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cache_addr;
    logic        cache_rd;
    logic [15:0] cache_q = '0;
    logic        mem_copy;
    logic [24:0] mem_copy_addr;
    logic [15:0] mem_copy_data;
    logic        mem_copy_we;
    logic        mem_ack = 1'b0;
    logic        sys_ready;
    logic        copy_err;
    logic        busy;

    boot_rom_copier #(
        .INIT_WAIT    (INIT_WAIT),
        .BASE_ADDR    (BASE),
        .CACHE_RD_LAT (LAT),
        .ACK_TIMEOUT  (TMO),
        .IMAGE_WORDS  (WORDS)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cache_addr    (cache_addr),
        .cache_rd      (cache_rd),
        .cache_q       (cache_q),
        .mem_copy      (mem_copy),
        .mem_copy_addr (mem_copy_addr),
        .mem_copy_data (mem_copy_data),
        .mem_copy_we   (mem_copy_we),
        .mem_ack       (mem_ack),
        .sys_ready     (sys_ready),
        .copy_err      (copy_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Expected outputs for the first cycles after reset release (cycle 0 is
    // the first cycle after the last edge that samples reset high).
    typedef struct {
        logic        rd;
        logic        bsy;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [12];

    int vectors;
    int miscompares;
    int cyc;
    int rel;
    int run;

    // Reference model state.
    logic [15:0] exp_rd_addr;
    logic [15:0] rd_addr;
    int          rd_time;
    int          words_rd;
    int          words_done;
    int          drop_cyc;
    int          last_drop;
    int          we_run;
    int          ack_dly;
    bit          prev_we;
    bit          prev_rd;
    bit          ack_prev;
    bit          exp_err;
    bit          rst_point;
    logic [15:0] sdram   [WORDS];
    bit          written [WORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc - rel, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_rd_addr = '0;
        rd_addr     = '0;
        rd_time     = -100;
        words_rd    = 0;
        words_done  = 0;
        drop_cyc    = -100;
        last_drop   = 1 << 30;
        we_run      = 0;
        ack_dly     = 2;
        prev_we     = 1'b0;
        prev_rd     = 1'b0;
        ack_prev    = 1'b0;
        exp_err     = 1'b0;
        rst_point   = 1'b0;
        for (int n = 0; n < WORDS; n++) begin
            sdram[n]   = '0;
            written[n] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cache_addr"},    32'(cache_addr),    32'h0);
        check({tag, "_cache_rd"},      32'(cache_rd),      32'h0);
        check({tag, "_mem_copy"},      32'(mem_copy),      32'h1);
        check({tag, "_mem_copy_addr"}, 32'(mem_copy_addr), 32'(BASE));
        check({tag, "_mem_copy_data"}, 32'(mem_copy_data), 32'h0);
        check({tag, "_mem_copy_we"},   32'(mem_copy_we),   32'h0);
        check({tag, "_sys_ready"},     32'(sys_ready),     32'h0);
        check({tag, "_copy_err"},      32'(copy_err),      32'h0);
        check({tag, "_busy"},          32'(busy),          32'h0);
    endtask

    // Compare DUT outputs of the current cycle against the reference model.
    task automatic observe();
        bit exp_ready;
        bit in_wait;

        // Write port: hold, drop on ack, drop on timeout.
        if (ack_prev) begin
            check("we_drop_after_ack", 32'(mem_copy_we), 32'h0);
        end else if (prev_we && we_run == 1 + TMO) begin
            check("we_drop_at_timeout", 32'(mem_copy_we), 32'h0);
        end

        if (mem_copy_we && !prev_we) begin
            check("we_rise_latency", 32'(cyc - rd_time), 32'(LAT + 1));
            check("wr_addr", 32'(mem_copy_addr), 32'(BASE + 25'(rd_addr)));
            check("wr_data", 32'(mem_copy_data), 32'(rd_addr ^ PATTERN));
            we_run  = 1;
            ack_dly = (words_done == 0) ? 2 : int'($urandom_range(4, 2));
        end else if (mem_copy_we) begin
            we_run++;
            check("wr_addr_hold", 32'(mem_copy_addr), 32'(BASE + 25'(rd_addr)));
            check("wr_data_hold", 32'(mem_copy_data), 32'(rd_addr ^ PATTERN));
        end else if (prev_we) begin
            if (!ack_prev) begin
                check("timeout_len", 32'(we_run), 32'(1 + TMO));
                exp_err = 1'b1;
            end
            drop_cyc = cyc;
            words_done++;
            if (words_done == WORDS) last_drop = cyc;
        end

        // Cache read port: one-cycle strobes at consecutive word addresses.
        if (cache_rd) begin
            check("rd_addr", 32'(cache_addr), 32'(exp_rd_addr));
            check("rd_pulse_width", 32'(prev_rd), 32'h0);
            if (words_rd == 0) check("first_rd_cycle", 32'(cyc - rel), 32'(INIT_WAIT));
            else               check("rd_after_next", 32'(cyc - drop_cyc), 32'd1);
            rd_time     = cyc;
            rd_addr     = exp_rd_addr;
            exp_rd_addr = exp_rd_addr + 16'd2;
            words_rd++;
        end

        // Status outputs.
        exp_ready = (words_done == WORDS) && (cyc > last_drop);
        in_wait   = (cyc - rel) < INIT_WAIT;
        check("sys_ready", 32'(sys_ready), 32'(exp_ready));
        check("mem_copy", 32'(mem_copy), 32'(!exp_ready));
        check("busy", 32'(busy), 32'(!in_wait && !exp_ready));
        check("copy_err", 32'(copy_err), 32'(exp_err));
        if (exp_ready || in_wait) begin
            check("rd_quiet", 32'(cache_rd), 32'h0);
            check("we_quiet", 32'(mem_copy_we), 32'h0);
        end

        if (run == 0 && mem_copy_we && we_run == 2 && rd_addr == RST_ADDR) rst_point = 1'b1;

        prev_we = mem_copy_we;
        prev_rd = cache_rd;
    endtask

    // Drive cache data and SDRAM acks for the current cycle.
    task automatic drive();
        int idx;
        ack_prev = 1'b0;
        if (words_rd > 0 && cyc == rd_time + LAT) cache_q = rd_addr ^ PATTERN;
        else                                      cache_q = 16'($urandom);

        if (mem_copy_we) begin
            if (we_run == ack_dly && rd_addr != SKIP_ADDR) begin
                mem_ack  = 1'b1;
                ack_prev = 1'b1;
                idx = int'((mem_copy_addr - BASE) >> 1);
                if (idx >= 0 && idx < WORDS) begin
                    sdram[idx]   = mem_copy_data;
                    written[idx] = 1'b1;
                end else begin
                    check("wr_addr_range", 32'(mem_copy_addr), 32'(BASE + 25'(rd_addr)));
                end
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_ack = ($urandom_range(3, 0) == 0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rst) observe();
        drive();
    endtask

    initial begin
        int  n;
        bit  stop;
        bit  aborted;

        //            rd    busy  we    cache_addr data
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};  // first read strobe
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hA5A5};  // write raised
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hA5A5};  // ack driven here
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hA5A5};  // advance
        tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'hA5A5};  // second word read

        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rel         = 0;
        run         = 0;
        aborted     = 1'b0;
        model_reset();

        repeat (3) step();
        check_reset_outputs("por");

        // Run 0 is interrupted by a reset mid-write; run 1 completes the image.
        for (int r = 0; r < 2 && !aborted; r++) begin
            run = r;
            model_reset();
            rst = 1'b0;
            rel = cyc;

            for (int i = 0; i < 12; i++) begin
                if (i > 0) step();
                check($sformatf("tbl%0d_cache_rd", i),      32'(cache_rd),      32'(tbl[i].rd));
                check($sformatf("tbl%0d_busy", i),          32'(busy),          32'(tbl[i].bsy));
                check($sformatf("tbl%0d_mem_copy_we", i),   32'(mem_copy_we),   32'(tbl[i].we));
                check($sformatf("tbl%0d_cache_addr", i),    32'(cache_addr),    32'(tbl[i].addr));
                check($sformatf("tbl%0d_mem_copy_data", i), 32'(mem_copy_data), 32'(tbl[i].data));
                check($sformatf("tbl%0d_mem_copy_addr", i), 32'(mem_copy_addr), 32'(BASE));
                check($sformatf("tbl%0d_mem_copy", i),      32'(mem_copy),      32'h1);
                check($sformatf("tbl%0d_sys_ready", i),     32'(sys_ready),     32'h0);
            end

            n    = 0;
            stop = 1'b0;
            while (!stop && n < BUDGET && miscompares < 50) begin
                step();
                n++;
                if (r == 0) stop = rst_point;
                else        stop = (words_done == WORDS) && (cyc > last_drop + 3);
            end

            if (!stop) begin
                vectors++;
                miscompares++;
                $display("FAIL run%0d_progress: stopped after %0d cycles at word %0d, expected %s",
                         r, n, words_done, (r == 0) ? "reset point 0x1234" : "copy complete");
                aborted = 1'b1;
            end else if (r == 0) begin
                // Reset for one cycle while waiting for the ack of word 0x1234.
                rst      = 1'b1;
                mem_ack  = 1'b0;
                ack_prev = 1'b0;
                step();
                check_reset_outputs("mid_copy_reset");
            end
        end

        if (!aborted) begin
            check("final_sys_ready", 32'(sys_ready), 32'h1);
            check("final_copy_err", 32'(copy_err), 32'h1);
            check("final_mem_copy", 32'(mem_copy), 32'h0);
            check("final_busy", 32'(busy), 32'h0);
            check("final_words_read", 32'(words_rd), 32'(WORDS));
            for (int w = 0; w < WORDS; w++) begin
                if (16'(2 * w) == SKIP_ADDR)
                    check($sformatf("sdram_skipped_%0h", 2 * w), 32'(written[w]), 32'h0);
                else
                    check($sformatf("sdram_%0h", 2 * w), {15'd0, written[w], sdram[w]},
                          {15'd0, 1'b1, 16'(2 * w) ^ PATTERN});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
